// File: rtl/register_file.sv
// Multi-entry flop-based register file: one write port, two registered read ports, synchronous clear.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module register_file #(
    parameter  int unsigned WIDTH  = 8,
    parameter  int unsigned DEPTH  = 8,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              writeEnable,
    input  logic [ADDR_W-1:0] writeAddr,
    input  logic [WIDTH-1:0]  writeData,
    input  logic              clear,
    input  logic [ADDR_W-1:0] readAddrA,
    input  logic [ADDR_W-1:0] readAddrB,
    output logic [WIDTH-1:0]  outA,
    output logic [WIDTH-1:0]  outB
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_hit_c;
    logic             rd_ok_a_c;
    logic             rd_ok_b_c;
    logic [WIDTH-1:0] next_a_c;
    logic [WIDTH-1:0] next_b_c;

    // A write only lands when in range and not overridden by clear.
    always_comb begin
        wr_hit_c  = writeEnable && !clear && (32'(writeAddr) < DEPTH);
        rd_ok_a_c = 32'(readAddrA) < DEPTH;
        rd_ok_b_c = 32'(readAddrB) < DEPTH;
    end

    // Read-data selection; out-of-range addresses and clear both yield zero.
    always_comb begin
        next_a_c = '0;
        next_b_c = '0;
        if (!clear) begin
            if (rd_ok_a_c) begin
                next_a_c = mem[readAddrA];
            end
            if (rd_ok_b_c) begin
                next_b_c = mem[readAddrB];
            end
`ifdef REGFILE_BYPASS_EN
            if (wr_hit_c && (readAddrA == writeAddr)) begin
                next_a_c = writeData;
            end
            if (wr_hit_c && (readAddrB == writeAddr)) begin
                next_b_c = writeData;
            end
`endif
        end
    end

    // Storage array.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_hit_c) begin
            mem[writeAddr] <= writeData;
        end
    end

    // Registered read ports.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outA <= '0;
            outB <= '0;
        end else begin
            outA <= next_a_c;
            outB <= next_b_c;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: two instances (8x8 and 16-bit x 6 entries) driven
// with shared control, checked every cycle against an array-based reference model.
module tb_register_file;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        we, clr;
    logic [2:0]  wa, ra, rb;
    logic [7:0]  wd0;
    logic [15:0] wd1;
    logic [7:0]  oa0, ob0;
    logic [15:0] oa1, ob1;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    // Reference state
    logic [7:0]  m0 [8];
    logic [15:0] m1 [6];
    logic [7:0]  ea0, eb0;
    logic [15:0] ea1, eb1;

    always #5 clk = ~clk;

    register_file #(.WIDTH(8), .DEPTH(8)) dut0 (
        .clk(clk), .reset(reset), .writeEnable(we), .writeAddr(wa), .writeData(wd0),
        .clear(clr), .readAddrA(ra), .readAddrB(rb), .outA(oa0), .outB(ob0));

    register_file #(.WIDTH(16), .DEPTH(6)) dut1 (
        .clk(clk), .reset(reset), .writeEnable(we), .writeAddr(wa), .writeData(wd1),
        .clear(clr), .readAddrA(ra), .readAddrB(rb), .outA(oa1), .outB(ob1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a read sees pre-edge contents (or the write data when forwarding), zero if
    // clear or out of range; then the array is cleared or written.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            foreach (m0[i]) m0[i] = '0;
            foreach (m1[i]) m1[i] = '0;
            ea0 = '0; eb0 = '0; ea1 = '0; eb1 = '0;
        end else begin
            bit ok0, ok1;
            ok0 = we && !clr && (wa < 8);
            ok1 = we && !clr && (wa < 6);
            if (clr) begin
                ea0 = '0; eb0 = '0; ea1 = '0; eb1 = '0;
            end else begin
                ea0 = (BYP && ok0 && ra == wa) ? wd0 : m0[ra];
                eb0 = (BYP && ok0 && rb == wa) ? wd0 : m0[rb];
                ea1 = (ra >= 6) ? 16'h0 : (BYP && ok1 && ra == wa) ? wd1 : m1[ra];
                eb1 = (rb >= 6) ? 16'h0 : (BYP && ok1 && rb == wa) ? wd1 : m1[rb];
            end
            if (clr) begin
                foreach (m0[i]) m0[i] = '0;
                foreach (m1[i]) m1[i] = '0;
            end else begin
                if (ok0) m0[wa] = wd0;
                if (ok1) m1[wa] = wd1;
            end
        end
    end

    // Per-cycle comparison, sampled just after the active edge.
    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            check("model_outA0", 32'(oa0), 32'(ea0));
            check("model_outB0", 32'(ob0), 32'(eb0));
            check("model_outA1", 32'(oa1), 32'(ea1));
            check("model_outB1", 32'(ob1), 32'(eb1));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic w, input logic [2:0] a, input logic [15:0] d,
                         input logic c, input logic [2:0] x, input logic [2:0] y);
        we = w; wa = a; wd0 = d[7:0]; wd1 = d; clr = c; ra = x; rb = y;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0);
        repeat (3) tick();
        check("reset_outA", 32'(oa0), 32'h0);
        check("reset_outB", 32'(ob1), 32'h0);
        reset = 1'b1;
        cmp_en = 1'b1;

        // Write A5 to entry 3, read it, then reset mid-cycle.
        drive(1'b1, 3'd3, 16'h00A5, 1'b0, 3'd0, 3'd0); tick();
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd3, 3'd3); tick();
        check("rd_entry3", 32'(oa0), 32'hA5);
        #2 reset = 1'b0;
        #1;
        check("async_rst_outA", 32'(oa0), 32'h0);
        check("async_rst_outB", 32'(ob0), 32'h0);
        check("async_rst_model", 32'(ea0), 32'h0);
        tick(); reset = 1'b1; tick();
        check("post_rst_entry3", 32'(oa0), 32'h0);

        // Write 3C to entry 5; both ports read it the next cycle.
        drive(1'b1, 3'd5, 16'h003C, 1'b0, 3'd0, 3'd0); tick();
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd5, 3'd5); tick();
        check("wr_rd_A", 32'(oa0), 32'h3C);
        check("wr_rd_B", 32'(ob0), 32'h3C);

        // Same-cycle write and read of entry 2.
        drive(1'b1, 3'd2, 16'h0011, 1'b0, 3'd0, 3'd0); tick();
        drive(1'b1, 3'd2, 16'h0077, 1'b0, 3'd2, 3'd0); tick();
        check("fwd_same_cycle", 32'(oa0), BYP ? 32'h77 : 32'h11);
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd2, 3'd0); tick();
        check("fwd_next_cycle", 32'(oa0), 32'h77);

        // Fill entries with index+1, then clear with a competing write.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 16'(i + 1), 1'b0, 3'd0, 3'd0); tick();
        end
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd4, 3'd7); tick();
        check("fill_entry4", 32'(oa0), 32'h5);
        check("fill_entry7", 32'(ob0), 32'h8);
        drive(1'b1, 3'd4, 16'h00FF, 1'b1, 3'd4, 3'd0); tick();
        check("clr_outA", 32'(oa0), 32'h0);
        check("clr_outB", 32'(ob0), 32'h0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 3'd0, 16'h0, 1'b0, 3'(i), 3'(7 - i)); tick();
            check("clr_entryA", 32'(oa0), 32'h0);
            check("clr_entryB", 32'(ob0), 32'h0);
        end

        // Out-of-range on the 6-entry instance.
        drive(1'b1, 3'd5, 16'h1234, 1'b0, 3'd0, 3'd0); tick();
        drive(1'b1, 3'd7, 16'hBEEF, 1'b0, 3'd7, 3'd0); tick();
        check("oor_same_cycle", 32'(oa1), 32'h0);
        drive(1'b1, 3'd6, 16'hCAFE, 1'b0, 3'd7, 3'd5); tick();
        check("oor_read7", 32'(oa1), 32'h0);
        check("oor_entry5", 32'(ob1), 32'h1234);
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd6, 3'd5); tick();
        check("oor_read6", 32'(oa1), 32'h0);
        check("oor_entry5_b", 32'(ob1), 32'h1234);

        // Randomized traffic with occasional clear and reset pulses.
        for (int n = 0; n < 10000; n++) begin
            drive(1'($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)), 16'($urandom),
                  1'($urandom_range(0, 31) == 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            reset = ($urandom_range(0, 499) != 0);
            tick();
        end
        reset = 1'b1;
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_file.md
# register_file

Parametrised multi-entry register file. It replaces the single 8-bit storage register in the CPU datapath. It has one write port, two registered read ports (A and B) for the ALU operand paths, and a synchronous clear-all. Optional write-to-read forwarding returns same-cycle write data on a read port without a stall.

## Interface
Parameters:
- WIDTH, 8, data width of each entry (≥1)
- DEPTH, 8, number of entries (≥2; need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width; derived, never overridden

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset (0 = in reset); deassertion is synchronised externally
- writeEnable  input  1  write writeData into entry writeAddr this edge
- writeAddr  input  ADDR_W  write address
- writeData  input  WIDTH  write data
- clear  input  1  synchronous clear of every entry and both read outputs
- readAddrA  input  ADDR_W  port A read address
- readAddrB  input  ADDR_W  port B read address
- outA  output  WIDTH  registered port A read data
- outB  output  WIDTH  registered port B read data

## Operation
- Storage: DEPTH × WIDTH flops, no RAM macro.
- Reset (reset=0): every entry = 0; outA = outB = 0. Takes effect immediately and asynchronously. It holds for as long as reset=0, including mid-operation. Any write pending in that cycle is lost.
- Write: on the edge with writeEnable=1 and clear=0, mem[writeAddr] ← writeData.
  - writeAddr ≥ DEPTH: write dropped, no entry changes.
- Read: on every edge, outA ← mem[readAddrA] and outB ← mem[readAddrB], using pre-edge contents.
  - Address ≥ DEPTH: the output loads 0.
  - Ports are independent. Equal addresses are legal and return identical data.
- Clear: on the edge with clear=1, every entry ← 0 and outA, outB ← 0.
  - Clear has priority over a same-cycle write; the write is dropped.
- Outputs hold their value only if the read address and the addressed contents are unchanged. No read enable exists.
- No other state. No FSM beyond reset/normal.

## Timing
- Write latency: data is stored at edge k. It is visible on a port whose address matches at edge k+1, through the registered read.
- Read latency: 1 cycle. The address presented before edge k gives data on outA/outB after edge k.
- Same-cycle write and read of the same in-range address at edge k:
  - With forwarding: the output gets writeData.
  - Without forwarding: the output gets the old contents.
- Simultaneous clear + write + read: all outputs and entries are 0 after the edge, regardless of forwarding.
- Reset assertion asynchronously zeroes outputs within the same cycle.
- The first edge after deassertion behaves as a normal cycle.

## Configuration
- Macro REGFILE_BYPASS_EN.
- Defined: a read port whose address equals an in-range writeAddr with writeEnable=1 and clear=0 loads writeData instead of mem contents (read-after-write forwarding, zero-bubble).
- Undefined: no forwarding. Same-cycle reads always return pre-write contents, and a consumer needs one extra cycle.
- Storage, clear, reset and out-of-range behaviour are identical either way.

## Test plan
- Reset: drive reset=0 mid-stream after writing 8'hA5 to entry 3 → outA=outB=0 immediately. After release, a read of entry 3 gives 0.
- Write/read: write 8'h3C to entry 5, then read A=5, B=5 next cycle → outA=outB=8'h3C one cycle after the address.
- Forwarding: entry 2 holds 8'h11. Write 8'h77 to entry 2 with readAddrA=2 in the same cycle.
  - REGFILE_BYPASS_EN defined → outA=8'h77.
  - Undefined → outA=8'h11, then 8'h77 the following cycle.
- Clear priority: entries 0..7 filled with index+1. Assert clear with writeEnable=1, writeAddr=4, writeData=8'hFF → every entry and both outputs read 0 on following cycles.
- Out-of-range: DEPTH=6, WIDTH=16. Write 16'hBEEF to address 7 → entries 0..5 unchanged; a read of address 7 returns 0; a read of address 5 is unaffected.
- Random: 10k cycles of random write/read/clear against a reference model, both macro settings, WIDTH∈{1,8,32}, DEPTH∈{2,8,13} → zero mismatches.
